// File: rtl/fpu_arb_pkg.sv
// fpu_arb_pkg: shared definitions for the two-requester FPU arbiter.
//   - FPU op encodings (sel field)
//   - arbiter FSM state type
//   - request payload struct {a, b, sel, rm}
package fpu_arb_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_RESP  = 2'b11
  } arb_state_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  sel;
    logic [1:0]  rm;
  } fpu_req_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: 2-way round-robin arbiter.
//   clk, rst_i   : clock, synchronous active-high reset
//   req_i[1:0]   : request vector
//   accept_i     : the current grant was taken; remember it as last grant
//   gnt_o[1:0]   : one-hot grant (zero when no request)
//   gnt_id_o     : index of the granted requester
// On a tie the requester that did not win last time is chosen. The
// last-grant register resets to 1 so requester 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);

  logic last_q;

  always_comb begin
    gnt_id_o = 1'b0;
    gnt_o    = '0;
    if (&req_i) begin
      gnt_id_o = ~last_q;
    end else begin
      gnt_id_o = req_i[1];
    end
    if (|req_i) begin
      gnt_o = gnt_id_o ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (accept_i) begin
      last_q <= gnt_id_o;
    end
  end

endmodule

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: shares one FPU between two valid/ready requesters.
//   clk, reset               : clock, synchronous active-high reset
//   req_valid/req_ready[1:0] : per-requester handshake (ready decoded in IDLE)
//   req{0,1}_{a,b,sel,rm}    : requester operands, op select, rounding mode
//   fpu_{a,b,sel,rm}, fpu_start : registered FPU issue interface
//   fpu_y, fpu_error, fpu_overflow : FPU result, valid RESULT_LATENCY
//                              cycles after the fpu_start cycle
//   rsp_valid/rsp_ready, rsp_id, rsp_y, rsp_error, rsp_overflow : response
//   busy                     : state is not IDLE
//   err_sticky, ovf_sticky, clr_flags : accumulated exception flags
// Optional: define FPU_ARB_PERF_CNT_EN to add op_cnt0/op_cnt1, 16-bit
// per-requester counts of completed responses (cleared by clr_flags).
// One operation is in flight at a time: IDLE -> ISSUE -> WAIT -> RESP.
module fpu_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int unsigned RESULT_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [1:0]  req0_sel,
  input  logic [1:0]  req1_sel,
  input  logic [1:0]  req0_rm,
  input  logic [1:0]  req1_rm,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [1:0]  fpu_sel,
  output logic [1:0]  fpu_rm,
  output logic        fpu_start,
  input  logic [31:0] fpu_y,
  input  logic        fpu_error,
  input  logic        fpu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_y,
  output logic        rsp_error,
  output logic        rsp_overflow,
  output logic        busy,
  output logic        err_sticky,
  output logic        ovf_sticky,
`ifdef FPU_ARB_PERF_CNT_EN
  output logic [15:0] op_cnt0,
  output logic [15:0] op_cnt1,
`endif
  input  logic        clr_flags
);

  arb_state_e  state_q;
  fpu_req_t    fpu_q;
  logic        start_q;
  logic        id_q;
  logic [3:0]  cnt_q;
  logic        rsp_valid_q;
  logic        rsp_id_q;
  logic [31:0] rsp_y_q;
  logic        rsp_err_q;
  logic        rsp_ovf_q;
  logic        err_sticky_q, err_sticky_d;
  logic        ovf_sticky_q, ovf_sticky_d;

  logic [1:0]  gnt;
  logic        gnt_id;
  logic        accept;
  logic        capture;
  fpu_req_t    req0_s, req1_s, sel_req;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst_i    (reset),
    .req_i    (req_valid),
    .accept_i (accept),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  // Ready is only offered in IDLE, so at most one bit can be high.
  assign req_ready = (state_q == S_IDLE) ? gnt : '0;
  assign accept    = |(req_valid & req_ready);
  assign busy      = (state_q != S_IDLE);
  assign capture   = (state_q == S_WAIT) && (cnt_q == 4'd1);

  always_comb begin
    req0_s  = '{a: req0_a, b: req0_b, sel: req0_sel, rm: req0_rm};
    req1_s  = '{a: req1_a, b: req1_b, sel: req1_sel, rm: req1_rm};
    sel_req = gnt_id ? req1_s : req0_s;
  end

  // A capture in the same cycle as clr_flags still leaves its flags set.
  always_comb begin
    err_sticky_d = (clr_flags ? 1'b0 : err_sticky_q) | (capture & fpu_error);
    ovf_sticky_d = (clr_flags ? 1'b0 : ovf_sticky_q) | (capture & fpu_overflow);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      fpu_q        <= '0;
      start_q      <= 1'b0;
      id_q         <= 1'b0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_y_q      <= '0;
      rsp_err_q    <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      start_q      <= 1'b0;
      err_sticky_q <= err_sticky_d;
      ovf_sticky_q <= ovf_sticky_d;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            fpu_q   <= sel_req;
            id_q    <= gnt_id;
            start_q <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= 4'(RESULT_LATENCY);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (capture) begin
            rsp_y_q     <= fpu_y;
            rsp_err_q   <= fpu_error;
            rsp_ovf_q   <= fpu_overflow;
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fpu_a        = fpu_q.a;
  assign fpu_b        = fpu_q.b;
  assign fpu_sel      = fpu_q.sel;
  assign fpu_rm       = fpu_q.rm;
  assign fpu_start    = start_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_y        = rsp_y_q;
  assign rsp_error    = rsp_err_q;
  assign rsp_overflow = rsp_ovf_q;
  assign err_sticky   = err_sticky_q;
  assign ovf_sticky   = ovf_sticky_q;

`ifdef FPU_ARB_PERF_CNT_EN
  logic [15:0] op_cnt0_q, op_cnt1_q;

  // clr_flags takes priority over a completion in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || clr_flags) begin
      op_cnt0_q <= '0;
      op_cnt1_q <= '0;
    end else if (rsp_valid_q && rsp_ready) begin
      if (rsp_id_q) begin
        op_cnt1_q <= op_cnt1_q + 16'd1;
      end else begin
        op_cnt0_q <= op_cnt0_q + 16'd1;
      end
    end
  end

  assign op_cnt0 = op_cnt0_q;
  assign op_cnt1 = op_cnt1_q;
`endif

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: directed stimulus with a response scoreboard for
// fpu_arbiter. A behavioural FPU returns table results exactly
// RESULT_LATENCY cycles after fpu_start and junk otherwise.
module tb_fpu_arbiter;

  localparam int unsigned LAT = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_sel, req1_sel, req0_rm, req1_rm;
  logic [31:0] fpu_a, fpu_b, fpu_y;
  logic [1:0]  fpu_sel, fpu_rm;
  logic        fpu_start, fpu_error, fpu_overflow;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_error, rsp_overflow;
  logic [31:0] rsp_y;
  logic        busy, err_sticky, ovf_sticky, clr_flags;
`ifdef FPU_ARB_PERF_CNT_EN
  logic [15:0] op_cnt0, op_cnt1;
`endif

  fpu_arbiter #(.RESULT_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_sel(req0_sel), .req1_sel(req1_sel),
    .req0_rm(req0_rm), .req1_rm(req1_rm),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_sel(fpu_sel), .fpu_rm(fpu_rm),
    .fpu_start(fpu_start), .fpu_y(fpu_y),
    .fpu_error(fpu_error), .fpu_overflow(fpu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_y(rsp_y), .rsp_error(rsp_error), .rsp_overflow(rsp_overflow),
    .busy(busy), .err_sticky(err_sticky), .ovf_sticky(ovf_sticky),
`ifdef FPU_ARB_PERF_CNT_EN
    .op_cnt0(op_cnt0), .op_cnt1(op_cnt1),
`endif
    .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        id;
    logic [31:0] y;
    logic        err;
    logic        ovf;
    int unsigned acc;
  } exp_t;
  exp_t sb[$];

  // Hand-computed IEEE-754 single results: {error, overflow, y}.
  function automatic logic [33:0] fpu_model(input logic [31:0] a, b,
                                             input logic [1:0] sel);
    if (sel == 2'b00 && a == 32'h3F800000 && b == 32'h40000000) return {2'b00, 32'h40400000};
    if (sel == 2'b10 && a == 32'h40000000 && b == 32'h40400000) return {2'b00, 32'h40C00000};
    if (sel == 2'b01 && a == 32'h40400000 && b == 32'h3F800000) return {2'b00, 32'h40000000};
    if (sel == 2'b11 && b == 32'h00000000) return {2'b11, 32'h7F800000};
    return {2'b10, 32'h7FC00000};
  endfunction

  // Behavioural FPU
  logic [33:0] fres = '0;
  int unsigned fcnt = 0;
  always @(posedge clk) begin
    if (fpu_start) begin
      fres <= fpu_model(fpu_a, fpu_b, fpu_sel);
      fcnt <= 1;
    end else if (fcnt != 0 && fcnt < 1000) begin
      fcnt <= fcnt + 1;
    end
  end
  always_comb begin
    if (fcnt == LAT) begin
      fpu_y        = fres[31:0];
      fpu_error    = fres[33];
      fpu_overflow = fres[32];
    end else begin
      fpu_y        = 32'hDEADBEEF;
      fpu_error    = 1'b1;
      fpu_overflow = 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out at cycle %0d", nm, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 80; k++) begin
      if (!busy && !rsp_valid) return;
      tick();
    end
    timeout_fail("wait_idle");
  endtask

  task automatic wait_ready(output logic [1:0] r);
    r = '0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        r = req_ready;
        return;
      end
    end
    timeout_fail("wait_ready");
  endtask

  // Acceptor pushes expectations; monitor pops on each response handshake.
  logic        rv_prev = 1'b0;
  int unsigned rise = 0;
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_t e;
          logic [33:0] m;
          m = (i == 0) ? fpu_model(req0_a, req0_b, req0_sel)
                       : fpu_model(req1_a, req1_b, req1_sel);
          e.id = (i == 1); e.y = m[31:0]; e.err = m[33]; e.ovf = m[32]; e.acc = cyc;
          sb.push_back(e);
        end
      end
      if (rsp_valid && !rv_prev) rise = cyc;
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          timeout_fail("unexpected_rsp");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_id", {31'b0, rsp_id}, {31'b0, e.id});
          chk("rsp_y", rsp_y, e.y);
          chk("rsp_error", {31'b0, rsp_error}, {31'b0, e.err});
          chk("rsp_overflow", {31'b0, rsp_overflow}, {31'b0, e.ovf});
          chk("rsp_latency", rise, e.acc + LAT + 2);
        end
      end
    end
    rv_prev = rsp_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [1:0] r;
  logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    reset = 1'b1; req_valid = '0; rsp_ready = 1'b1; clr_flags = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    req0_sel = '0; req1_sel = '0; req0_rm = 2'b01; req1_rm = 2'b10;
    repeat (3) tick();
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_fpu_start", {31'b0, fpu_start}, 32'd0);
    chk("rst_err_sticky", {31'b0, err_sticky}, 32'd0);
    chk("rst_fpu_a", fpu_a, 32'd0);
    reset = 1'b0;
    tick();

    // Both valid from reset: grants alternate 0,1,0,1
    req0_a = 32'h40000000; req0_b = 32'h40400000; req0_sel = 2'b10;
    req1_a = 32'h40400000; req1_b = 32'h3F800000; req1_sel = 2'b01;
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      wait_ready(r);
      chk("grant_order", {30'b0, r}, {30'b0, exp_g[g]});
      tick();
    end
    req_valid = '0;
    wait_idle();

    // Single requester 0 add: issue timing and operand hold
    req0_a = 32'h3F800000; req0_b = 32'h40000000; req0_sel = 2'b00;
    req_valid = 2'b01;
    #1 chk("ready_idle", {30'b0, req_ready}, 32'd1);
    tick();
    req_valid = '0;
    chk("start_after_accept", {31'b0, fpu_start}, 32'd1);
    chk("fpu_a", fpu_a, 32'h3F800000);
    chk("fpu_b", fpu_b, 32'h40000000);
    chk("fpu_rm", {30'b0, fpu_rm}, 32'd1);
    chk("busy_issue", {31'b0, busy}, 32'd1);
    tick();
    chk("start_one_cycle", {31'b0, fpu_start}, 32'd0);
    wait_idle();

    // Response stall: outputs hold, no new accept, then starved req1 served
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    wait_ready(r);
    tick();
    req_valid = 2'b10;
    for (int k = 0; k < 30 && !rsp_valid; k++) tick();
    if (!rsp_valid) timeout_fail("stall_rsp_valid");
    for (int k = 0; k < 5; k++) begin
      chk("stall_rsp_y", rsp_y, 32'h40400000);
      chk("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("stall_req_ready", {30'b0, req_ready}, 32'd0);
      chk("stall_busy", {31'b0, busy}, 32'd1);
      chk("stall_no_start", {31'b0, fpu_start}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    wait_ready(r);
    chk("starved_grant", {30'b0, r}, 32'd2);
    tick();
    req_valid = '0;
    wait_idle();

    // Divide by zero: sticky flags, clear, and clear-vs-capture
    req0_a = 32'h3F800000; req0_b = 32'h00000000; req0_sel = 2'b11;
    req_valid = 2'b01;
    wait_ready(r);
    tick();
    req_valid = '0;
    wait_idle();
    chk("err_sticky_set", {31'b0, err_sticky}, 32'd1);
    chk("ovf_sticky_set", {31'b0, ovf_sticky}, 32'd1);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    chk("err_sticky_clr", {31'b0, err_sticky}, 32'd0);
    chk("ovf_sticky_clr", {31'b0, ovf_sticky}, 32'd0);
    req_valid = 2'b01;
    wait_ready(r);
    tick();
    req_valid = '0;
    repeat (LAT) @(posedge clk);
    #1 clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("err_set_wins", {31'b0, err_sticky}, 32'd1);
    chk("ovf_set_wins", {31'b0, ovf_sticky}, 32'd1);
    wait_idle();

    // Reset while waiting on the FPU
    req0_a = 32'h3F800000; req0_b = 32'h40000000; req0_sel = 2'b00;
    req_valid = 2'b01;
    wait_ready(r);
    tick();
    req_valid = '0;
    tick();
    reset = 1'b1;
    sb.delete();
    tick();
    chk("rstwait_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rstwait_busy", {31'b0, busy}, 32'd0);
    chk("rstwait_fpu_start", {31'b0, fpu_start}, 32'd0);
    chk("rstwait_err_sticky", {31'b0, err_sticky}, 32'd0);
    reset = 1'b0;
    tick();
    req0_sel = 2'b00;
    req_valid = 2'b11;
    #1 chk("post_reset_grant", {30'b0, req_ready}, 32'd1);
    tick();
    req_valid = '0;
    wait_idle();

    // Three requester-0 completions after a clear
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid = 2'b01;
      wait_ready(r);
      tick();
      req_valid = '0;
      wait_idle();
    end
`ifdef FPU_ARB_PERF_CNT_EN
    chk("op_cnt0", {16'b0, op_cnt0}, 32'd3);
    chk("op_cnt1", {16'b0, op_cnt1}, 32'd0);
`endif

    repeat (3) tick();
    chk("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
